// File: rtl/time_base_pkg.sv
// Shared constants for the time base block.
package time_base_pkg;
  localparam int CNT_W_D     = 32;
  localparam int PRESC_W_D   = 16;
  localparam int N_CMP_D     = 4;
  localparam int SYNC_STAGES = 3;
endpackage

// File: rtl/tick_sync_edge.sv
// tick_in synchroniser and rising-edge detector.
module tick_sync_edge
  import time_base_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic edge_p
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-2:0] vld_q;
  logic                   armed;

  // armed stays low until a genuine low has reached the detector, so a
  // tick_in already high when rst releases is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      vld_q  <= '0;
      armed  <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      vld_q  <= {vld_q[SYNC_STAGES-3:0], 1'b1};
      if (vld_q[SYNC_STAGES-2] && !sync_q[SYNC_STAGES-2])
        armed <= 1'b1;
      edge_p <= armed & sync_q[SYNC_STAGES-2]
              & ~sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/time_base_ctrl.sv
// Prescaled tick accumulator with load, capture and compare channels.
module time_base_ctrl
  import time_base_pkg::*;
#(
  parameter int CNT_W   = CNT_W_D,
  parameter int PRESC_W = PRESC_W_D,
  parameter int N_CMP   = N_CMP_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_in,
  input  logic                   clr,
  input  logic [PRESC_W-1:0]     presc,
  input  logic                   load,
  input  logic [CNT_W-1:0]       load_val,
  input  logic                   cap_stb,
  input  logic [N_CMP*CNT_W-1:0] cmp_val,
  input  logic [N_CMP-1:0]       cmp_en,
  output logic [CNT_W-1:0]       q,
  output logic                   tick_ev,
  output logic [CNT_W-1:0]       cap_q,
  output logic                   cap_vld,
  output logic [N_CMP-1:0]       cmp_hit,
  output logic                   wrap
);

  logic               tick_p;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] sch;
  logic [CNT_W-1:0]   acc;
  logic               upd_r;
  logic [N_CMP-1:0]   cmp_next;

  tick_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .edge_p  (tick_p)
  );

  assign q = acc;

  // upd_r marks the cycle where acc shows a freshly written value,
  // so a match fires once and not again while acc holds.
  always_comb begin
    cmp_next = '0;
    for (int i = 0; i < N_CMP; i++)
      cmp_next[i] = upd_r & cmp_en[i]
                  & (acc == cmp_val[i*CNT_W +: CNT_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
      sch     <= '0;
      acc     <= '0;
      upd_r   <= 1'b0;
      tick_ev <= 1'b0;
      wrap    <= 1'b0;
      cap_q   <= '0;
      cap_vld <= 1'b0;
      cmp_hit <= '0;
    end else begin
      presc_r <= presc;
      tick_ev <= tick_p;
      wrap    <= 1'b0;
      upd_r   <= 1'b0;
      cap_vld <= cap_stb;
      cmp_hit <= cmp_next;
      if (cap_stb)
        cap_q <= acc;
      if (clr) begin
        acc   <= '0;
        sch   <= '0;
        upd_r <= 1'b1;
      end else if (load) begin
        acc   <= load_val;
        sch   <= '0;
        upd_r <= 1'b1;
      end else if (tick_p) begin
        if (sch >= presc_r) begin
          sch   <= '0;
          acc   <= acc + CNT_W'(1);
          upd_r <= 1'b1;
          wrap  <= &acc;
        end else begin
          sch <= sch + PRESC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_base_ctrl.sv
// Self-checking bench for time_base_ctrl.
module tb_time_base_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick_in;
  logic         clr;
  logic [15:0]  presc;
  logic         load;
  logic [31:0]  load_val;
  logic         cap_stb;
  logic [127:0] cmp_val;
  logic [3:0]   cmp_en;
  logic [31:0]  q;
  logic         tick_ev;
  logic [31:0]  cap_q;
  logic         cap_vld;
  logic [3:0]   cmp_hit;
  logic         wrap;

  time_base_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .clr      (clr),
    .presc    (presc),
    .load     (load),
    .load_val (load_val),
    .cap_stb  (cap_stb),
    .cmp_val  (cmp_val),
    .cmp_en   (cmp_en),
    .q        (q),
    .tick_ev  (tick_ev),
    .cap_q    (cap_q),
    .cap_vld  (cap_vld),
    .cmp_hit  (cmp_hit),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic        w;
  } ev_t;

  typedef struct {
    int          presc;
    int          edges;
    logic [31:0] exp_q;
  } vec_t;

  ev_t  tq[$];
  ev_t  hq[$];
  ev_t  cq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   wrap_cnt = 0;
  int   hit_cnt = 0;
  logic [31:0] m_q;
  int   m_sch;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic stray(input string nm, input logic [63:0] got);
    checks++;
    $display("FAIL %s: got %0h expected none", nm, got);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (wrap === 1'b1) wrap_cnt++;
    if (tick_ev === 1'b1) begin
      if (tq.size() == 0) stray("tick_ev_stray", 64'(cyc));
      else begin
        e = tq.pop_front();
        chk("tick_ev_cycle", 64'(cyc), 64'(e.cyc));
        chk("tick_q", 64'(q), 64'(e.val));
        chk("tick_wrap", 64'(wrap), 64'(e.w));
      end
    end else if (wrap === 1'b1) stray("wrap_stray", 64'(cyc));
    if (cmp_hit !== 4'b0 && !rst) begin
      hit_cnt++;
      if (hq.size() == 0) stray("cmp_hit_stray", 64'(cmp_hit));
      else begin
        e = hq.pop_front();
        chk("hit_cycle", 64'(cyc), 64'(e.cyc));
        chk("hit_mask", 64'(cmp_hit), 64'(e.val));
      end
    end
    if (cap_vld === 1'b1) begin
      if (cq.size() == 0) stray("cap_vld_stray", 64'(cyc));
      else begin
        e = cq.pop_front();
        chk("cap_cycle", 64'(cyc), 64'(e.cyc));
        chk("cap_q", 64'(cap_q), 64'(e.val));
      end
    end
  end

  function automatic logic [3:0] hit_mask();
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      m[i] = cmp_en[i] && (cmp_val[i*32 +: 32] == m_q);
    return m;
  endfunction

  task automatic model_upd(input bit ld, input bit cl,
                           input logic [31:0] lv, input bit tk,
                           output bit upd, output bit w);
    upd = 1'b0;
    w   = 1'b0;
    if (cl) begin
      m_q = '0; m_sch = 0; upd = 1'b1;
    end else if (ld) begin
      m_q = lv; m_sch = 0; upd = 1'b1;
    end else if (tk) begin
      if (m_sch >= int'(presc)) begin
        w = (m_q == 32'hFFFF_FFFF);
        m_q = m_q + 32'd1;
        m_sch = 0;
        upd = 1'b1;
      end else m_sch++;
    end
  endtask

  task automatic push_hit(input int at);
    ev_t e;
    logic [3:0] m;
    m = hit_mask();
    if (m != 4'b0) begin
      e.cyc = at; e.val = 32'(m); e.w = 1'b0;
      hq.push_back(e);
    end
  endtask

  task automatic tick_edge(input bit ld = 0, input bit cl = 0,
                           input bit cp = 0,
                           input logic [31:0] lv = 32'd0);
    ev_t e;
    int n;
    bit upd, w;
    logic [31:0] pre;
    @(posedge clk); #1;
    n = cyc;
    tick_in = 1'b1;
    pre = m_q;
    model_upd(ld, cl, lv, 1'b1, upd, w);
    e.cyc = n + 4; e.val = m_q; e.w = w;
    tq.push_back(e);
    if (upd) push_hit(n + 5);
    repeat (3) @(posedge clk);
    #1;
    tick_in = 1'b0;
    load = ld; clr = cl; cap_stb = cp; load_val = lv;
    if (cp) begin
      e.cyc = n + 4; e.val = pre; e.w = 1'b0;
      cq.push_back(e);
    end
    @(posedge clk); #1;
    load = 1'b0; clr = 1'b0; cap_stb = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic strobe(input bit ld, input bit cl,
                        input logic [31:0] lv);
    bit upd, w;
    @(posedge clk); #1;
    load = ld; clr = cl; load_val = lv;
    model_upd(ld, cl, lv, 1'b0, upd, w);
    push_hit(cyc + 2);
    @(posedge clk); #1;
    load = 1'b0; clr = 1'b0;
  endtask

  task automatic capture(input int cnt);
    ev_t e;
    @(posedge clk); #1;
    cap_stb = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      e.cyc = cyc + 1; e.val = m_q; e.w = 1'b0;
      cq.push_back(e);
      @(posedge clk); #1;
    end
    cap_stb = 1'b0;
  endtask

  vec_t tbl[4];
  int   w0, h0;

  initial begin
    tbl[0] = '{presc: 3, edges: 16, exp_q: 32'd4};
    tbl[1] = '{presc: 0, edges: 5,  exp_q: 32'd5};
    tbl[2] = '{presc: 1, edges: 7,  exp_q: 32'd3};
    tbl[3] = '{presc: 2, edges: 8,  exp_q: 32'd2};

    rst = 1'b1; tick_in = 1'b0; clr = 1'b0; presc = '0;
    load = 1'b0; load_val = '0; cap_stb = 1'b0;
    cmp_val = '0; cmp_en = '0;
    m_q = '0; m_sch = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", 64'(q), 0);
    chk("rst_cap_q", 64'(cap_q), 0);
    chk("rst_cap_vld", 64'(cap_vld), 0);
    chk("rst_cmp_hit", 64'(cmp_hit), 0);
    chk("rst_wrap", 64'(wrap), 0);
    chk("rst_tick_ev", 64'(tick_ev), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    foreach (tbl[k]) begin
      presc = 16'(tbl[k].presc);
      strobe(1'b0, 1'b1, 32'd0);
      repeat (2) @(posedge clk);
      for (int j = 0; j < tbl[k].edges; j++) tick_edge();
      @(negedge clk);
      chk($sformatf("table_q_%0d", k), 64'(q), 64'(tbl[k].exp_q));
    end

    presc = 16'd0;
    w0 = wrap_cnt;
    strobe(1'b1, 1'b0, 32'hFFFF_FFFE);
    repeat (2) @(posedge clk);
    repeat (3) tick_edge();
    @(negedge clk);
    chk("wrap_final_q", 64'(q), 64'd1);
    chk("wrap_count", 64'(wrap_cnt - w0), 64'd1);

    presc = 16'd1;
    strobe(1'b0, 1'b1, 32'd0);
    repeat (2) @(posedge clk);
    tick_edge();
    tick_edge(1'b1, 1'b0, 1'b0, 32'd100);
    @(negedge clk);
    chk("load_over_tick_q", 64'(q), 64'd100);
    tick_edge();
    @(negedge clk);
    chk("load_cleared_sch", 64'(q), 64'd100);
    tick_edge();
    @(negedge clk);
    chk("after_load_inc", 64'(q), 64'd101);
    tick_edge(1'b1, 1'b1, 1'b0, 32'd55);
    @(negedge clk);
    chk("clr_over_load", 64'(q), 64'd0);

    presc = 16'd0;
    cmp_val = '0;
    cmp_val[31:0]  = 32'd5;
    cmp_val[63:32] = 32'd9;
    cmp_val[95:64] = 32'd5;
    cmp_val[127:96] = 32'd7;
    cmp_en = 4'b0101;
    strobe(1'b0, 1'b1, 32'd0);
    repeat (2) @(posedge clk);
    h0 = hit_cnt;
    repeat (5) tick_edge();
    repeat (8) @(posedge clk);
    tick_edge();
    @(negedge clk);
    chk("cmp_hit_once", 64'(hit_cnt - h0), 64'd1);
    chk("cmp_q_after", 64'(q), 64'd6);
    cmp_en = 4'b0;

    strobe(1'b0, 1'b1, 32'd0);
    repeat (2) @(posedge clk);
    repeat (7) tick_edge();
    tick_edge(1'b0, 1'b0, 1'b1);
    capture(1);
    capture(3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cap_hold", 64'(cap_q), 64'd8);

    presc = 16'd3;
    strobe(1'b1, 1'b0, 32'd50);
    repeat (2) @(posedge clk);
    tick_edge();
    tick_edge();
    @(posedge clk); #1;
    rst = 1'b1;
    tick_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst2_q", 64'(q), 0);
    chk("rst2_cap_q", 64'(cap_q), 0);
    chk("rst2_outs", 64'({cap_vld, cmp_hit, wrap, tick_ev}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_q = '0; m_sch = 0;
    repeat (10) @(posedge clk);
    #1 tick_in = 1'b0;
    repeat (3) @(posedge clk);
    tick_edge();
    @(negedge clk);
    chk("rst2_sch_discard", 64'(q), 0);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("tick_q_empty", 64'(tq.size()), 0);
    chk("hit_q_empty", 64'(hq.size()), 0);
    chk("cap_q_empty", 64'(cq.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/time_base_ctrl.md
TIME_BASE_CTRL -- requirements
Module: time_base_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: accumulator width in bits, range 8..64.
REQ-002 Parameter PRESC_W, default 16: prescaler compare width in bits.
REQ-003 Parameter N_CMP, default 4: number of compare channels, range 1..8.
REQ-004 Reset rst, synchronous, active-high; clock clk.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 tick_in  in  1  reference tick, asynchronous to clk, high and low each for at least 2 clk periods.
REQ-008 clr  in  1  synchronous clear of accumulator and prescaler.
REQ-009 presc  in  PRESC_W  divider: one accumulator increment per presc+1 tick rising edges.
REQ-010 load  in  1  one-cycle strobe; loads load_val into accumulator.
REQ-011 load_val  in  CNT_W  value for load.
REQ-012 cap_stb  in  1  one-cycle capture request.
REQ-013 cmp_val  in  N_CMP*CNT_W  compare values; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-014 cmp_en  in  N_CMP  per-channel compare enable.
REQ-015 q  out  CNT_W  accumulator value.
REQ-016 tick_ev  out  1  one-cycle pulse for each detected tick rising edge.
REQ-017 cap_q  out  CNT_W  captured accumulator value.
REQ-018 cap_vld  out  1  one-cycle pulse marking cap_q update.
REQ-019 cmp_hit  out  N_CMP  one-cycle per-channel match pulse.
REQ-020 wrap  out  1  one-cycle pulse on accumulator rollover.

Function
REQ-021 tick_in SHALL pass through a 3-flop synchroniser; a rising edge is detected when the two oldest stages show 0 then 1.
REQ-022 tick_ev SHALL pulse exactly 3 clk cycles after the first clk edge that samples tick_in high; q SHALL update on the same cycle as tick_ev.
REQ-023 presc SHALL be registered every cycle (presc_r); a change affects the next tick edge.
REQ-024 Prescaler counter sch: on tick edge, if sch >= presc_r then sch<=0 and accumulator += 1, else sch += 1.
REQ-025 presc=0 SHALL increment on every tick edge; lowering presc below sch SHALL increment on the next edge, with no long wrap.
REQ-026 Priority in any cycle: rst > clr > load > tick increment. clr sets accumulator=0 and sch=0; load sets accumulator=load_val and sch=0.
REQ-027 Increment from all-ones SHALL wrap to 0 and assert wrap in the cycle q first shows 0; load and clr never assert wrap.
REQ-028 cap_stb SHALL copy q as seen in the strobe cycle (pre-update value) into cap_q on the next edge, with cap_vld high for that one cycle.
REQ-029 cap_q SHALL hold between captures; back-to-back strobes SHALL capture on every cycle.
REQ-030 cmp_hit[i] SHALL pulse one cycle after any accumulator update (increment, load, clr) that makes q equal cmp_val[i] with cmp_en[i]=1.
REQ-031 cmp_hit[i] SHALL NOT repeat while q holds the matching value.
REQ-032 Multiple channels with equal cmp_val SHALL assert their hits simultaneously.

Reset
REQ-033 On rst: q=0, sch=0, presc_r=0, cap_q=0, cap_vld=0, cmp_hit=0, wrap=0, tick_ev=0, synchroniser flops=0.
REQ-034 rst mid-count SHALL discard prescaler progress; after rst, a tick_in already high SHALL NOT produce an edge until it goes low then high.

Structure
REQ-035 Package time_base_pkg SHALL hold the default CNT_W/PRESC_W/N_CMP constants and the sync-stage count (3).
REQ-036 Sub-module tick_sync_edge SHALL implement the synchroniser and edge detector; all other logic stays in time_base_ctrl.

Verification
REQ-037 presc=3, 16 tick edges -> q steps 0->4, with tick_ev pulsing 16 times, each 3 cycles after tick_in sampled high.
REQ-038 load_val=32'hFFFF_FFFE, presc=0, 3 edges -> q = FFFF_FFFF, 0, 1; wrap pulses once, with q=0.
REQ-039 load and tick-edge increment in the same cycle, load_val=100 -> q=100, sch=0; clr together with load -> q=0.
REQ-040 cmp_val[0]=cmp_val[2]=5, cmp_en=4'b0101, count from 0 -> cmp_hit=0101 for one cycle after q=5; none while q stays 5.
REQ-041 cap_stb in the increment cycle from 7 to 8 -> cap_q=7 with cap_vld one cycle; next strobe -> cap_q=8.
REQ-042 rst asserted with sch=2, presc=3 -> all outputs 0; tick_in held high through rst release -> no tick_ev until a low-high transition.
